acc_c_responder: RTL and testbench

ACC_C_RESPONDER -- requirements
Module: acc_c_responder

---
 rtl/acc_c_responder.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_acc_c_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_c_responder.sv
// acc_c_responder: C-interface accelerator responder.
// Requests are buffered in a Depth-entry FIFO; only the head is issued to the
// execution unit, one operation at a time, and its result is returned on the
// response channel in request order.  An operation whose destination register
// (instr_data[11:7]) is x0 completes without a response.
// Optional feature: define ACC_C_RESPONDER_TIMEOUT_EN to build in a watchdog
// that aborts a stuck operation after TimeoutCycles cycles in WAIT.

package acc_pkg;

    localparam int unsigned NumRs       = 3;
    localparam int unsigned HartIdWidth = 5;

    typedef struct packed {
        logic [31:0]                addr;
        logic [NumRs-1:0][31:0]     rs;
        logic [31:0]                instr_data;
        logic [HartIdWidth-1:0]     hart_id;
    } acc_c_req_chan_t;

    typedef struct packed {
        acc_c_req_chan_t q;
        logic            q_valid;
        logic            p_ready;
    } acc_c_req_t;

    typedef struct packed {
        logic [31:0]            data;
        logic                   error;
        logic [4:0]             rd;
        logic [HartIdWidth-1:0] hart_id;
        logic                   dualwb;
    } acc_c_rsp_chan_t;

    typedef struct packed {
        acc_c_rsp_chan_t p;
        logic            p_valid;
        logic            q_ready;
    } acc_c_rsp_t;

endpackage

module acc_c_responder #(
    parameter int unsigned Depth         = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  acc_pkg::acc_c_req_t                 acc_c_req_i,
    output acc_pkg::acc_c_rsp_t                 acc_c_rsp_o,
    output logic                                ex_valid_o,
    input  logic                                ex_ready_i,
    output logic [31:0]                         ex_instr_o,
    output logic [acc_pkg::NumRs-1:0][31:0]     ex_rs_o,
    input  logic                                ex_result_valid_i,
    input  logic [31:0]                         ex_result_i,
    input  logic                                ex_error_i,
    output logic                                ex_flush_o
);

    // Elaboration-time guard on the parameter ranges.
    if (Depth < 1 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
        $error("acc_c_responder: Depth must be >= 1 and TimeoutCycles in 1..65535");
    end

    // Pointer width stays at least one bit so Depth = 1 still elaborates.
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [CntW-1:0] ZeroCnt  = {CntW{1'b0}};
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [PtrW-1:0] ZeroPtr  = {PtrW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = ZeroPtr;
        end else begin
            nxt = ptr + {{(PtrW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    acc_pkg::acc_c_req_chan_t fifo_mem_r [Depth];
    logic [PtrW-1:0]          wr_ptr_r;
    logic [PtrW-1:0]          rd_ptr_r;
    logic [CntW-1:0]          count_r;
    logic [CntW-1:0]          count_next_s;
    logic                     q_ready_r;
    logic                     push_s;
    logic                     pop_s;
    logic                     empty_s;

    logic [31:0]                       head_instr_s;
    logic [acc_pkg::NumRs-1:0][31:0]   head_rs_s;
    logic [acc_pkg::HartIdWidth-1:0]   head_hart_s;
    logic [4:0]                        head_rd_s;

    // The push qualifier is the registered q_ready, which reflects the fill
    // level before any same-cycle pop, so a full FIFO never takes a request.
    assign push_s  = acc_c_req_i.q_valid & q_ready_r;
    assign empty_s = (count_r == ZeroCnt);

    assign head_instr_s = fifo_mem_r[rd_ptr_r].instr_data;
    assign head_rs_s    = fifo_mem_r[rd_ptr_r].rs;
    assign head_hart_s  = fifo_mem_r[rd_ptr_r].hart_id;
    assign head_rd_s    = head_instr_s[11:7];

    // Next fill level from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{(CntW-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(CntW-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because count_r gates their use.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= acc_c_req_i.q;
        end
    end

    // FIFO pointers, fill level and registered q_ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r  <= ZeroPtr;
            rd_ptr_r  <= ZeroPtr;
            count_r   <= ZeroCnt;
            q_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r   <= count_next_s;
            q_ready_r <= (count_next_s != DepthCnt);
        end
    end

    // ------------------------------------------------------------------
    // Operation sequencer
    // ------------------------------------------------------------------
    state_e                            state_r;
    logic                              ex_valid_r;
    logic [31:0]                       ex_instr_r;
    logic [acc_pkg::NumRs-1:0][31:0]   ex_rs_r;
    logic                              p_valid_r;
    logic [31:0]                       p_data_r;
    logic                              p_error_r;
    logic [4:0]                        p_rd_r;
    logic [acc_pkg::HartIdWidth-1:0]   p_hart_r;

`ifdef ACC_C_RESPONDER_TIMEOUT_EN
    localparam logic [15:0] TimerLast = 16'(TimeoutCycles - 1);
    logic [15:0] timer_r;
    logic        flush_r;
`endif

    // The head leaves the FIFO when its response is taken, or when an x0
    // result completes silently.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_WAIT: pop_s = ex_result_valid_i & (head_rd_s == 5'd0);
            ST_RESP: pop_s = acc_c_req_i.p_ready;
            default: pop_s = 1'b0;
        endcase
    end

    // FSM with registered execution-side and response-side outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            ex_valid_r <= 1'b0;
            ex_instr_r <= 32'd0;
            ex_rs_r    <= {(acc_pkg::NumRs*32){1'b0}};
            p_valid_r  <= 1'b0;
            p_data_r   <= 32'd0;
            p_error_r  <= 1'b0;
            p_rd_r     <= 5'd0;
            p_hart_r   <= {acc_pkg::HartIdWidth{1'b0}};
`ifdef ACC_C_RESPONDER_TIMEOUT_EN
            timer_r    <= 16'd0;
            flush_r    <= 1'b0;
`endif
        end else begin
`ifdef ACC_C_RESPONDER_TIMEOUT_EN
            flush_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_r    <= ST_ISSUE;
                        ex_valid_r <= 1'b1;
                        ex_instr_r <= head_instr_s;
                        ex_rs_r    <= head_rs_s;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (ex_ready_i) begin
                        state_r    <= ST_WAIT;
                        ex_valid_r <= 1'b0;
                        ex_instr_r <= 32'd0;
                        ex_rs_r    <= {(acc_pkg::NumRs*32){1'b0}};
`ifdef ACC_C_RESPONDER_TIMEOUT_EN
                        timer_r    <= 16'd0;
`endif
                    end else begin
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle takes priority.
                    if (ex_result_valid_i) begin
                        if (head_rd_s == 5'd0) begin
                            state_r   <= ST_IDLE;
                        end else begin
                            state_r   <= ST_RESP;
                            p_valid_r <= 1'b1;
                            p_data_r  <= ex_result_i;
                            p_error_r <= ex_error_i;
                            p_rd_r    <= head_rd_s;
                            p_hart_r  <= head_hart_s;
                        end
                    end
`ifdef ACC_C_RESPONDER_TIMEOUT_EN
                    else if (timer_r == TimerLast) begin
                        state_r   <= ST_RESP;
                        p_valid_r <= 1'b1;
                        p_data_r  <= 32'd0;
                        p_error_r <= 1'b1;
                        p_rd_r    <= head_rd_s;
                        p_hart_r  <= head_hart_s;
                        flush_r   <= 1'b1;
                    end else begin
                        timer_r   <= timer_r + 16'd1;
                    end
`else
                    else begin
                        state_r   <= ST_WAIT;
                    end
`endif
                end
                ST_RESP: begin
                    if (acc_c_req_i.p_ready) begin
                        state_r   <= ST_IDLE;
                        p_valid_r <= 1'b0;
                        p_data_r  <= 32'd0;
                        p_error_r <= 1'b0;
                        p_rd_r    <= 5'd0;
                        p_hart_r  <= {acc_pkg::HartIdWidth{1'b0}};
                    end else begin
                        state_r   <= ST_RESP;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ex_valid_r <= 1'b0;
                    p_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output assembly from registered state only.
    always_comb begin
        acc_c_rsp_o           = {$bits(acc_pkg::acc_c_rsp_t){1'b0}};
        acc_c_rsp_o.p.data    = p_data_r;
        acc_c_rsp_o.p.error   = p_error_r;
        acc_c_rsp_o.p.rd      = p_rd_r;
        acc_c_rsp_o.p.hart_id = p_hart_r;
        acc_c_rsp_o.p.dualwb  = 1'b0;
        acc_c_rsp_o.p_valid   = p_valid_r;
        acc_c_rsp_o.q_ready   = q_ready_r;
    end

    assign ex_valid_o = ex_valid_r;
    assign ex_instr_o = ex_instr_r;
    assign ex_rs_o    = ex_rs_r;

`ifdef ACC_C_RESPONDER_TIMEOUT_EN
    assign ex_flush_o = flush_r;
`else
    assign ex_flush_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_c_responder.sv
// Self-checking bench for acc_c_responder: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model (queue of pending requests + head phase).
module tb_acc_c_responder;
    import acc_pkg::*;

    localparam int Depth = 2;
    localparam int Tmo   = 8;

    logic clk = 1'b0;
    logic rst;
    acc_c_req_t req;
    acc_c_rsp_t rsp;
    logic ex_valid, ex_ready, ex_rv, ex_err, ex_flush;
    logic [31:0] ex_instr, ex_result;
    logic [NumRs-1:0][31:0] ex_rs;

    acc_c_responder #(.Depth(Depth), .TimeoutCycles(Tmo)) dut (
        .clk_i(clk), .rst_i(rst),
        .acc_c_req_i(req), .acc_c_rsp_o(rsp),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_instr_o(ex_instr), .ex_rs_o(ex_rs),
        .ex_result_valid_i(ex_rv), .ex_result_i(ex_result), .ex_error_i(ex_err),
        .ex_flush_o(ex_flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]            instr;
        logic [NumRs*32-1:0]    rs;
        logic [HartIdWidth-1:0] hart;
    } op_t;

    int n_vec = 0;
    int n_err = 0;

    // Model: pending requests; head phase 0=not issued, 1=executing, 2=responding
    op_t         mq[$];
    int          phase = 0;
    logic [31:0] m_data = 32'd0;
    logic        m_err = 1'b0;
    logic        m_flush = 1'b0;
    int          wait_cnt = 0;
    int          stall = 0;
    logic        s_ex_valid, s_q_ready;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic pop;
        pop = 1'b0;
        m_flush = 1'b0;
        if (rst) begin
            mq.delete();
            phase = 0;
            stall = 0;
            return;
        end
        if (phase == 0 && s_ex_valid && ex_ready) begin
            phase = 1;
            wait_cnt = 0;
        end else if (phase == 1) begin
            if (ex_rv) begin
                if (mq[0].instr[11:7] == 5'd0) pop = 1'b1;
                else begin
                    phase = 2; m_data = ex_result; m_err = ex_err;
                end
            end
`ifdef ACC_C_RESPONDER_TIMEOUT_EN
            else begin
                wait_cnt++;
                if (wait_cnt == Tmo) begin
                    phase = 2; m_data = 32'd0; m_err = 1'b1; m_flush = 1'b1;
                end
            end
`endif
        end else if (phase == 2 && req.p_ready) begin
            pop = 1'b1;
        end
        if (pop) begin
            void'(mq.pop_front());
            phase = 0;
        end
        if (req.q_valid && s_q_ready)
            mq.push_back('{instr: req.q.instr_data, rs: req.q.rs, hart: req.q.hart_id});
    endtask

    task automatic compare();
        if (rst) begin
            chk("rst_q_ready", rsp.q_ready, 1'b0);
            chk("rst_p_valid", rsp.p_valid, 1'b0);
            chk("rst_p", rsp.p, '0);
            chk("rst_ex_valid", ex_valid, 1'b0);
            chk("rst_ex_instr", ex_instr, 32'd0);
            chk("rst_ex_rs", ex_rs, '0);
            chk("rst_flush", ex_flush, 1'b0);
            return;
        end
        chk("q_ready", rsp.q_ready, mq.size() < Depth);
        chk("flush", ex_flush, m_flush);
        if (phase == 2) begin
            chk("p_valid", rsp.p_valid, 1'b1);
            chk("p_data", rsp.p.data, m_data);
            chk("p_error", rsp.p.error, m_err);
            chk("p_rd", rsp.p.rd, mq[0].instr[11:7]);
            chk("p_hart", rsp.p.hart_id, mq[0].hart);
            chk("p_dualwb", rsp.p.dualwb, 1'b0);
        end else begin
            chk("p_valid_idle", rsp.p_valid, 1'b0);
        end
        if (phase != 0 || mq.size() == 0) begin
            chk("ex_valid_idle", ex_valid, 1'b0);
            stall = 0;
        end else if (ex_valid) begin
            chk("ex_instr", ex_instr, mq[0].instr);
            chk("ex_rs", ex_rs, mq[0].rs);
            stall = 0;
        end else begin
            stall++;
            chk("issue_latency", stall <= 1, 1'b1);
        end
    endtask

    task automatic cycle();
        s_ex_valid = ex_valid;
        s_q_ready  = rsp.q_ready;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic send(logic [31:0] instr, logic [HartIdWidth-1:0] hart);
        logic acc;
        acc = 1'b0;
        req.q.instr_data = instr;
        req.q.hart_id    = hart;
        req.q.addr       = $urandom;
        req.q.rs         = {$urandom, $urandom, $urandom};
        req.q_valid      = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = rsp.q_ready;
            cycle();
        end
        req.q_valid = 1'b0;
        chk("send_accepted", acc, 1'b1);
    endtask

    task automatic finish_one(logic [31:0] data, logic [4:0] rd);
        logic got;
        got = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            got = ex_valid;
            cycle();
        end
        ex_ready = 1'b0;
        chk("issue_seen", got, 1'b1);
        ex_rv = 1'b1; ex_result = data; ex_err = 1'b0;
        cycle();
        ex_rv = 1'b0;
        chk("lit_p_valid", rsp.p_valid, 1'b1);
        chk("lit_p_data", rsp.p.data, data);
        chk("lit_p_rd", rsp.p.rd, rd);
        req.p_ready = 1'b1;
        cycle();
        req.p_ready = 1'b0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        req = '0; ex_ready = 1'b0; ex_rv = 1'b0; ex_err = 1'b0; ex_result = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        compare();
        chk("lit_rst_q_ready", rsp.q_ready, 1'b0);
        rst = 1'b0;
        cycle();
        chk("lit_q_ready_after_rst", rsp.q_ready, 1'b1);

        // Single request rd=5 hart=3, result 0xDEADBEEF, response held 10 cycles.
        send(32'h0000_02B3, 5'd3);
        ex_ready = 1'b1;
        cycle();
        chk("lit_ex_valid", ex_valid, 1'b1);
        chk("lit_ex_instr", ex_instr, 32'h0000_02B3);
        cycle();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        ex_rv = 1'b1; ex_result = 32'hDEAD_BEEF; ex_err = 1'b0;
        cycle();
        ex_rv = 1'b0;
        chk("lit_p_valid", rsp.p_valid, 1'b1);
        chk("lit_p_data", rsp.p.data, 32'hDEAD_BEEF);
        chk("lit_p_rd", rsp.p.rd, 5'd5);
        chk("lit_p_hart", rsp.p.hart_id, 5'd3);
        chk("lit_p_error", rsp.p.error, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("lit_hold_valid", rsp.p_valid, 1'b1);
            chk("lit_hold_data", rsp.p.data, 32'hDEAD_BEEF);
        end
        req.p_ready = 1'b1;
        cycle();
        req.p_ready = 1'b0;
        chk("lit_p_valid_done", rsp.p_valid, 1'b0);

        // rd=0 completes silently; next request issues.
        send(32'h0000_0033, 5'd1);
        send(32'h0000_0393, 5'd2);
        ex_ready = 1'b1;
        cycle();
        ex_ready = 1'b0;
        ex_rv = 1'b1; ex_result = 32'h1111_1111;
        cycle();
        ex_rv = 1'b0;
        chk("lit_rd0_no_resp", rsp.p_valid, 1'b0);
        cycle();
        chk("lit_next_issue", ex_valid, 1'b1);
        chk("lit_next_instr", ex_instr, 32'h0000_0393);
        finish_one(32'h1234_5678, 5'd7);

        // Three back-to-back requests into a 2-deep queue.
        send(32'h0000_00B3, 5'd4);
        send(32'h0000_0133, 5'd5);
        chk("lit_full_q_ready", rsp.q_ready, 1'b0);
        req.q.instr_data = 32'h0000_01B3; req.q_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("lit_still_full", rsp.q_ready, 1'b0);
        req.q_valid = 1'b0;
        finish_one(32'h0000_000A, 5'd1);
        send(32'h0000_01B3, 5'd6);
        finish_one(32'h0000_000B, 5'd2);
        finish_one(32'h0000_000C, 5'd3);

        // Reset in WAIT with two queued.
        send(32'h0000_0233, 5'd1);
        send(32'h0000_0333, 5'd2);
        ex_ready = 1'b1;
        cycle();
        ex_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("lit_rst_ex_valid", ex_valid, 1'b0);
        chk("lit_rst_p_valid", rsp.p_valid, 1'b0);
        chk("lit_rst_q_ready2", rsp.q_ready, 1'b0);
        ex_rv = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("lit_q_ready_rel", rsp.q_ready, 1'b1);
        cycle();
        ex_rv = 1'b0;
        chk("lit_no_stale_resp", rsp.p_valid, 1'b0);
        send(32'h0000_02B3, 5'd9);
        finish_one(32'h0000_0055, 5'd5);

`ifdef ACC_C_RESPONDER_TIMEOUT_EN
        // Watchdog: no result for Tmo WAIT cycles.
        send(32'h0000_02B3, 5'd4);
        ex_ready = 1'b1;
        cycle();
        cycle();
        ex_ready = 1'b0;
        for (int i = 0; i < Tmo - 1; i++) cycle();
        chk("lit_no_flush_yet", ex_flush, 1'b0);
        cycle();
        chk("lit_flush", ex_flush, 1'b1);
        chk("lit_tmo_error", rsp.p.error, 1'b1);
        chk("lit_tmo_data", rsp.p.data, 32'd0);
        ex_rv = 1'b1; ex_result = 32'hFFFF_FFFF;
        cycle();
        ex_rv = 1'b0;
        chk("lit_late_ignored", rsp.p.data, 32'd0);
        req.p_ready = 1'b1;
        cycle();
        req.p_ready = 1'b0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            req.q_valid      = ($urandom % 2) == 0;
            req.q.addr       = $urandom;
            req.q.rs         = {$urandom, $urandom, $urandom};
            req.q.hart_id    = 5'($urandom);
            req.q.instr_data = $urandom;
            req.q.instr_data[11:7] = 5'($urandom_range(0, 3));
            req.p_ready      = ($urandom % 3) == 0;
            ex_ready         = ($urandom % 3) != 0;
            ex_rv            = (phase == 1) ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
            ex_result        = $urandom;
            ex_err           = ($urandom % 5) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
